// File: rtl/aes128_host_if.sv
// aes128_host_if
// Byte-stream front end for an AES-128 core. A command byte, an optional
// 16-byte key and a 16-byte block arrive on a valid/ready byte stream. The
// block drives the core inputs and waits a fixed latency. It then returns
// the core result as 16 bytes on a transmit valid/ready stream.
// All multi-byte values are big-endian: the first byte on the wire is [127:120].
module aes128_host_if #(
    parameter int unsigned CORE_LATENCY = 11
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rx_valid,
    input  logic [7:0]   rx_data,
    output logic         rx_ready,
    output logic         tx_valid,
    output logic [7:0]   tx_data,
    input  logic         tx_ready,
    output logic         core_mode,
    output logic [127:0] core_key,
    output logic [127:0] core_in,
    input  logic [127:0] core_out,
    output logic         busy
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        KEY  = 3'd1,
        MSG  = 3'd2,
        WAIT = 3'd3,
        SEND = 3'd4
    } state_t;

    // The counter runs CORE_LATENCY-1 down to 0, so the capture edge lands
    // exactly CORE_LATENCY edges after core_in is updated.
    localparam logic [7:0] WAIT_LOAD = 8'(CORE_LATENCY - 1);

    state_t         state_reg;
    state_t         state_next;

    logic           rx_ready_reg;
    logic           tx_valid_reg;
    logic [3:0]     rx_count_reg;
    logic [3:0]     tx_count_reg;
    logic [7:0]     wait_count_reg;
    logic [127:0]   asm_reg;
    logic [127:0]   shift_reg;
    logic           core_mode_reg;
    logic [127:0]   core_key_reg;
    logic [127:0]   core_in_reg;

    logic           rx_fire;
    logic           tx_fire;
    logic [127:0]   asm_shift;
    logic [127:0]   tx_shift;

    // FSM strobes produced by the next-state process
    logic           mode_load;
    logic           key_commit;
    logic           msg_commit;
    logic           out_capture;
    logic           rx_shift_en;
    logic           rx_phase_now;
    logic           rx_phase_next;

    assign rx_fire = rx_valid && rx_ready_reg;
    assign tx_fire = tx_valid_reg && tx_ready;

    // Byte-lane wiring: the assembly register shifts in at the bottom, the
    // transmit register shifts out at the top.
    genvar gi;
    generate
        for (gi = 0; gi < 15; gi++) begin : g_lane
            assign asm_shift[8*gi+15 -: 8] = asm_reg[8*gi+7 -: 8];
            assign tx_shift[8*gi+15 -: 8]  = shift_reg[8*gi+7 -: 8];
        end
    endgenerate
    assign asm_shift[7:0] = rx_data;
    assign tx_shift[7:0]  = 8'h00;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and per-cycle strobes
    always_comb begin
        state_next  = state_reg;
        mode_load   = 1'b0;
        key_commit  = 1'b0;
        msg_commit  = 1'b0;
        out_capture = 1'b0;
        rx_shift_en = 1'b0;
        case (state_reg)
            IDLE: begin
                if (rx_fire) begin
                    mode_load  = 1'b1;
                    state_next = rx_data[1] ? KEY : MSG;
                end
            end
            KEY: begin
                if (rx_fire) begin
                    rx_shift_en = 1'b1;
                    if (rx_count_reg == 4'd15) begin
                        key_commit = 1'b1;
                        state_next = MSG;
                    end
                end
            end
            MSG: begin
                if (rx_fire) begin
                    rx_shift_en = 1'b1;
                    if (rx_count_reg == 4'd15) begin
                        msg_commit = 1'b1;
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (wait_count_reg == 8'd0) begin
                    out_capture = 1'b1;
                    state_next  = SEND;
                end
            end
            SEND: begin
                if (tx_fire && (tx_count_reg == 4'd15)) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // rx_ready is granted only while both the current and the next state
    // accept bytes: it drops on the edge taking the last MSG byte, and
    // returns one cycle after SEND hands back to IDLE (and one edge after reset).
    assign rx_phase_now  = (state_reg == IDLE) || (state_reg == KEY) || (state_reg == MSG);
    assign rx_phase_next = (state_next == IDLE) || (state_next == KEY) || (state_next == MSG);

    // Handshake flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_ready_reg <= 1'b0;
            tx_valid_reg <= 1'b0;
        end else begin
            rx_ready_reg <= rx_phase_now && rx_phase_next;
            tx_valid_reg <= (state_next == SEND);
        end
    end

    // Receive byte counter and assembly register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_count_reg <= 4'd0;
            asm_reg      <= '0;
        end else if (rx_shift_en) begin
            rx_count_reg <= rx_count_reg + 4'd1;
            asm_reg      <= asm_shift;
        end
    end

    // Core-facing registers: only ever written with complete values
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            core_mode_reg <= 1'b0;
            core_key_reg  <= '0;
            core_in_reg   <= '0;
        end else begin
            if (mode_load) begin
                core_mode_reg <= rx_data[0];
            end
            if (key_commit) begin
                core_key_reg <= asm_shift;
            end
            if (msg_commit) begin
                core_in_reg <= asm_shift;
            end
        end
    end

    // Core latency counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_count_reg <= 8'd0;
        end else if (msg_commit) begin
            wait_count_reg <= WAIT_LOAD;
        end else if ((state_reg == WAIT) && (wait_count_reg != 8'd0)) begin
            wait_count_reg <= wait_count_reg - 8'd1;
        end
    end

    // Transmit shift register and byte counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_reg    <= '0;
            tx_count_reg <= 4'd0;
        end else if (out_capture) begin
            shift_reg    <= core_out;
            tx_count_reg <= 4'd0;
        end else if ((state_reg == SEND) && tx_fire) begin
            shift_reg    <= tx_shift;
            tx_count_reg <= tx_count_reg + 4'd1;
        end
    end

    assign rx_ready  = rx_ready_reg;
    assign tx_valid  = tx_valid_reg;
    assign tx_data   = shift_reg[127:120];
    assign core_mode = core_mode_reg;
    assign core_key  = core_key_reg;
    assign core_in   = core_in_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_aes128_host_if.sv
// Bench for aes128_host_if: a latency-accurate stand-in core, a table of
// command vectors, and hand-written reset sequences.
module tb_aes128_host_if;

    localparam int L = 11;

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] ALT_PT   = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] ALT_CT0  = 128'ha486e0c22c0e684a5b791f3dd3f197b5; // ALT_PT ^ a5.., key 0, encrypt

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         rx_valid = 1'b0;
    logic [7:0]   rx_data = 8'h00;
    logic         rx_ready;
    logic         tx_valid;
    logic [7:0]   tx_data;
    logic         tx_ready = 1'b1;
    logic         core_mode;
    logic [127:0] core_key;
    logic [127:0] core_in;
    logic [127:0] core_out;
    logic         busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int txn = 0;

    aes128_host_if #(.CORE_LATENCY(L)) dut (
        .clk(clk), .reset(reset),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .core_mode(core_mode), .core_key(core_key), .core_in(core_in),
        .core_out(core_out), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in core: knows the FIPS-197 vector both ways, otherwise a simple
    // keyed XOR that still depends on the mode bit.
    function automatic logic [127:0] core_fn(input logic m, input logic [127:0] k,
                                             input logic [127:0] d);
        logic [127:0] pad;
        pad = {16{8'ha5}};
        if (k == FIPS_KEY && !m && d == FIPS_PT) return FIPS_CT;
        if (k == FIPS_KEY && m && d == FIPS_CT) return FIPS_PT;
        return d ^ k ^ pad ^ {127'd0, m};
    endfunction

    // Output becomes valid after L-1 edges, ready to be sampled at edge L.
    logic [127:0] pipe [L-1];
    always @(posedge clk) begin
        pipe[0] <= core_fn(core_mode, core_key, core_in);
        for (int k = 1; k < L - 1; k++) pipe[k] <= pipe[k-1];
    end
    assign core_out = pipe[L-2];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic acc;
        int t;
        rx_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        rx_valid = 1'b1;
        rx_data  = b;
        t = 0;
        do begin
            acc = rx_ready;
            @(posedge clk); #1;
            t++;
        end while (!acc && t < 50);
        if (!acc) begin
            n_vec++; n_err++;
            $display("FAIL rx_accept: byte %h not taken within 50 cycles", b);
        end
        rx_valid = 1'b0;
    endtask

    // Full command; abort_at >= 0 returns after that many result bytes.
    task automatic run_cmd(input logic [7:0] cmd, input logic [127:0] key,
                           input logic [127:0] data, input int gap_max,
                           input int stall_at, input int abort_at,
                           input logic exp_mode, input logic [127:0] exp_key,
                           input logic [127:0] exp_out);
        int e0;
        int t;
        logic [7:0] hold;
        logic [127:0] got;
        got = '0;
        send_byte(cmd, 0);
        chk("core_mode_load", core_mode, exp_mode);
        if (cmd[1]) begin
            for (int i = 0; i < 16; i++)
                send_byte(key[127-8*i -: 8], $urandom_range(0, gap_max));
        end
        chk("core_key", core_key, exp_key);
        for (int i = 0; i < 16; i++)
            send_byte(data[127-8*i -: 8], $urandom_range(0, gap_max));
        e0 = cyc;
        chk("core_in", core_in, data);
        chk("busy_wait", busy, 1);
        // Offer a 17th byte throughout WAIT and SEND; it must never be taken.
        rx_valid = 1'b1;
        rx_data  = 8'h5a;
        t = 0;
        while (!tx_valid && t < L + 8) begin
            chk("rx_ready_wait", rx_ready, 0);
            @(posedge clk); #1;
            t++;
        end
        if (!tx_valid) begin
            n_vec++; n_err++;
            $display("FAIL tx_valid_timeout: no result after %0d cycles", t);
            rx_valid = 1'b0;
            return;
        end
        chk("tx_latency", 128'(cyc - e0), 128'(L));
        for (int i = 0; i < 16; i++) begin
            if (i == abort_at) begin
                rx_valid = 1'b0;
                return;
            end
            if (i == stall_at) begin
                tx_ready = 1'b0;
                hold = tx_data;
                repeat (5) begin
                    @(posedge clk); #1;
                    chk("tx_hold", tx_data, hold);
                end
                tx_ready = 1'b1;
            end
            chk("tx_valid", tx_valid, 1);
            chk("rx_ready_send", rx_ready, 0);
            chk("tx_byte", tx_data, exp_out[127-8*i -: 8]);
            got = {got[119:0], tx_data};
            @(posedge clk); #1;
        end
        chk("tx_valid_drop", tx_valid, 0);
        chk("busy_done", busy, 0);
        chk("core_in_stable", core_in, data);
        chk("core_mode_stable", core_mode, exp_mode);
        rx_valid = 1'b0;
        @(posedge clk); #1;
        chk("rx_ready_return", rx_ready, 1);
        $display("txn %0d cmd %h out %h expected %h", txn, cmd, got, exp_out);
        txn++;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_core_key", core_key, 0);
        chk("rst_core_in", core_in, 0);
        chk("rst_rx_ready", rx_ready, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_core_mode", core_mode, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        chk("rx_ready_before_edge", rx_ready, 0);
        @(posedge clk); #1;
        chk("rx_ready_after_release", rx_ready, 1);
    endtask

    typedef struct {
        logic [7:0]   cmd;
        logic [127:0] key;
        logic [127:0] data;
        int           gap_max;
        int           stall_at;
        logic         exp_mode;
        logic [127:0] exp_key;
        logic [127:0] exp_out;
    } vec_t;

    vec_t vecs [4];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'h02, FIPS_KEY, FIPS_PT, 0, -1, 1'b0, FIPS_KEY, FIPS_CT};
        vecs[1] = '{8'h01, 128'h0, FIPS_CT, 0, -1, 1'b1, FIPS_KEY, FIPS_PT};
        vecs[2] = '{8'h00, 128'h0, FIPS_PT, 4, 7, 1'b0, FIPS_KEY, FIPS_CT};
        vecs[3] = '{8'hfe, FIPS_KEY, FIPS_PT, 2, -1, 1'b0, FIPS_KEY, FIPS_CT};

        do_reset();

        for (int v = 0; v < 4; v++)
            run_cmd(vecs[v].cmd, vecs[v].key, vecs[v].data, vecs[v].gap_max,
                    vecs[v].stall_at, -1, vecs[v].exp_mode, vecs[v].exp_key,
                    vecs[v].exp_out);

        // Reset after the 9th key byte: old key stays whole until cleared.
        send_byte(8'h02, 0);
        for (int i = 0; i < 9; i++) begin
            send_byte(FIPS_KEY[127-8*i -: 8], 0);
            chk("key_no_partial", core_key, FIPS_KEY);
        end
        do_reset();
        run_cmd(8'h02, FIPS_KEY, FIPS_PT, 1, -1, -1, 1'b0, FIPS_KEY, FIPS_CT);

        // Reset after the 5th result byte, then a keyless command uses key 0.
        run_cmd(8'h00, 128'h0, FIPS_PT, 0, -1, 5, 1'b0, FIPS_KEY, FIPS_CT);
        chk("tx_valid_before_abort", tx_valid, 1);
        do_reset();
        run_cmd(8'h00, 128'h0, ALT_PT, 0, -1, -1, 1'b0, 128'h0, ALT_CT0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
